// File: rtl/lsu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_bus_pkg
// Description : Shared types and constants for the LSU-to-bus adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_bus_pkg;

    // Adapter access sequence: accept, present request, await response, report
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int MASK_W          = 4;
    localparam int DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_counter
// Description : Cycle counter bounding a bus access; flags the final allowed
//               cycle so the adapter can abandon the access.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear has priority; the forced exit at TIMEOUT-1 means no wrap is possible
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/lsu_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module      : lsu_bus_adapter
// Description : Converts the single-cycle LSU load/store request into a
//               valid/ready + rvalid bus access, stalling the pipeline until
//               the access completes or times out.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_bus_adapter
    import lsu_bus_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [MASK_W-1:0] mask_i,
    output logic              stall_o,
    output logic              rvalid_o,
    output logic [DW-1:0]     rdata_o,
    output logic              err_o,
    output logic              bus_valid_o,
    input  logic              bus_ready_i,
    output logic              bus_we_o,
    output logic [AW-1:0]     bus_addr_o,
    output logic [DW-1:0]     bus_wdata_o,
    output logic [MASK_W-1:0] bus_mask_o,
    input  logic              bus_rvalid_i,
    input  logic [DW-1:0]     bus_rdata_i,
    input  logic              bus_err_i
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              expired;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == IDLE),
        .enable_i  ((state_q == REQ) || (state_q == RESP)),
        .expired_o (expired)
    );

    // Next-state, payload latch and response capture
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    mask_d  = mask_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Timeout wins: bus_valid_o is already low this cycle, so no
                // handshake can be in flight when the access is abandoned
                if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus_ready_i) begin
                    if (bus_rvalid_i) begin
                        rdata_d = (we_q || bus_err_i) ? '0 : bus_rdata_i;
                        err_d   = bus_err_i;
                        state_d = DONE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus_rvalid_i) begin
                    rdata_d = (we_q || bus_err_i) ? '0 : bus_rdata_i;
                    err_d   = bus_err_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                // req_i here still belongs to the retiring instruction
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, payload and response registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall_o     = ((state_q == IDLE) && req_i) || (state_q == REQ) || (state_q == RESP);
    assign rvalid_o    = (state_q == DONE);
    assign rdata_o     = (state_q == DONE) ? rdata_q : '0;
    assign err_o       = (state_q == DONE) ? err_q : 1'b0;
    assign bus_valid_o = (state_q == REQ) && !expired;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_mask_o  = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_bus_adapter
// Description : Self-checking bench for lsu_bus_adapter: per-cycle vector
//               table plus hand-written asynchronous reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_adapter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req, we;
    logic [31:0]   addr, wdata, b_rdata;
    logic [3:0]    mask;
    logic          stall, vld_o, err_o;
    logic [31:0]   rdata_o;
    logic          b_valid, b_ready, b_we, b_rvalid, b_err;
    logic [31:0]   b_addr, b_wdata;
    logic [3:0]    b_mask;

    lsu_bus_adapter #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .mask_i       (mask),
        .stall_o      (stall),
        .rvalid_o     (vld_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .bus_valid_o  (b_valid),
        .bus_ready_i  (b_ready),
        .bus_we_o     (b_we),
        .bus_addr_o   (b_addr),
        .bus_wdata_o  (b_wdata),
        .bus_mask_o   (b_mask),
        .bus_rvalid_i (b_rvalid),
        .bus_rdata_i  (b_rdata),
        .bus_err_i    (b_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        be;
        logic        e_stall;
        logic        e_vld;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_bvalid;
        logic        chk_pay;
    } vec_t;

    vec_t        vq[$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Current transaction payload, also the expected bus payload
    logic        t_we;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_mask;

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        t_we = w; t_addr = a; t_wdata = d; t_mask = m;
    endtask

    function automatic vec_t mk(input logic r, input logic q, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic be, input logic es,
                                input logic ev, input logic [31:0] erd, input logic ee,
                                input logic ebv);
        vec_t v;
        v.rst_n = r;  v.req = q;  v.we = t_we; v.addr = t_addr; v.wdata = t_wdata;
        v.mask = t_mask; v.rdy = rdy; v.rv = rv; v.rd = rd; v.be = be;
        v.e_stall = es; v.e_vld = ev; v.e_rdata = erd; v.e_err = ee; v.e_bvalid = ebv;
        v.chk_pay = ebv | ~r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and check before the rising edge
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
        mask = v.mask; b_ready = v.rdy; b_rvalid = v.rv; b_rdata = v.rd; b_err = v.be;
        #1;
        n_vec++;
        chk($sformatf("v%0d stall", idx),     {31'd0, stall},   {31'd0, v.e_stall});
        chk($sformatf("v%0d rvalid", idx),    {31'd0, vld_o},   {31'd0, v.e_vld});
        chk($sformatf("v%0d rdata", idx),     rdata_o,          v.e_rdata);
        chk($sformatf("v%0d err", idx),       {31'd0, err_o},   {31'd0, v.e_err});
        chk($sformatf("v%0d bus_valid", idx), {31'd0, b_valid}, {31'd0, v.e_bvalid});
        if (v.chk_pay) begin
            chk($sformatf("v%0d bus_we", idx),    {31'd0, b_we},  {31'd0, v.we});
            chk($sformatf("v%0d bus_addr", idx),  b_addr,         v.addr);
            chk($sformatf("v%0d bus_wdata", idx), b_wdata,        v.wdata);
            chk($sformatf("v%0d bus_mask", idx),  {28'd0, b_mask}, {28'd0, v.mask});
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; mask = '0;
        b_ready = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_err = 1'b0;

        // ---------------- vector table ----------------
        // Reset state: everything 0
        txn(1'b0, 32'h0, 32'h0, 4'h0);
        vq.push_back(mk(0,0,0,0,32'h0,0, 0,0,32'h0,0,0));
        vq.push_back(mk(0,0,1,1,32'hFFFF_FFFF,1, 0,0,32'h0,0,0));

        // Zero-wait load; bus_rvalid in IDLE afterwards is ignored
        txn(1'b0, 32'h10, 32'h0, 4'hF);
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,0));
        vq.push_back(mk(1,1,1,0,32'h0,0,         1,0,32'h0,0,1));
        vq.push_back(mk(1,1,0,1,32'hDEADBEEF,0,  1,0,32'h0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,0,         0,1,32'hDEADBEEF,0,0));
        vq.push_back(mk(1,0,0,1,32'hFFFF0000,0,  0,0,32'h0,0,0));
        vq.push_back(mk(1,0,0,0,32'h0,0,         0,0,32'h0,0,0));

        // Store with 3 cycles of backpressure; store response data discarded
        txn(1'b1, 32'h20, 32'h12345678, 4'b0011);
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,1));
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,1));
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,1));
        vq.push_back(mk(1,1,1,0,32'h0,0,         1,0,32'h0,0,1));
        vq.push_back(mk(1,1,0,1,32'hAAAA5555,0,  1,0,32'h0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,0,         0,1,32'h0,0,0));
        vq.push_back(mk(1,0,0,0,32'h0,0,         0,0,32'h0,0,0));

        // Same-cycle ready + rvalid: REQ straight to DONE
        txn(1'b0, 32'h44, 32'h0, 4'b1100);
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,0));
        vq.push_back(mk(1,1,1,1,32'hCAFEF00D,0,  1,0,32'h0,0,1));
        vq.push_back(mk(1,1,0,0,32'h0,0,         0,1,32'hCAFEF00D,0,0));
        vq.push_back(mk(1,0,0,0,32'h0,0,         0,0,32'h0,0,0));

        // Error response on a load: data forced to 0
        txn(1'b0, 32'h80, 32'h0, 4'hF);
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,0));
        vq.push_back(mk(1,1,1,0,32'h0,0,         1,0,32'h0,0,1));
        vq.push_back(mk(1,1,0,1,32'h00001234,1,  1,0,32'h0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,0,         0,1,32'h0,1,0));
        vq.push_back(mk(1,0,0,0,32'h0,0,         0,0,32'h0,0,0));

        // Timeout in REQ: 8 cycles in REQ, valid dropped in the last one
        txn(1'b0, 32'h100, 32'h0, 4'hF);
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,0));
        for (int k = 0; k < TO - 1; k++)
            vq.push_back(mk(1,1,0,0,32'h0,0,     1,0,32'h0,0,1));
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,0,         0,1,32'h0,1,0));
        vq.push_back(mk(1,0,0,0,32'h0,0,         0,0,32'h0,0,0));

        // Timeout in RESP: accepted but never answered
        txn(1'b1, 32'h104, 32'h55, 4'hF);
        vq.push_back(mk(1,1,0,0,32'h0,0,         1,0,32'h0,0,0));
        vq.push_back(mk(1,1,1,0,32'h0,0,         1,0,32'h0,0,1));
        for (int k = 0; k < TO - 1; k++)
            vq.push_back(mk(1,1,0,0,32'h0,0,     1,0,32'h0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,0,         0,1,32'h0,1,0));
        vq.push_back(mk(1,0,0,0,32'h0,0,         0,0,32'h0,0,0));

        foreach (vq[i]) run_vec(i, vq[i]);

        // ---------------- reset mid-REQ ----------------
        txn(1'b0, 32'h180, 32'h0, 4'hF);
        run_vec(1000, mk(1,1,0,0,32'h0,0, 1,0,32'h0,0,0));
        run_vec(1001, mk(1,1,0,0,32'h0,0, 1,0,32'h0,0,1));
        @(negedge clk);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        chk("rst_req bus_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_req stall",     {31'd0, stall},   32'd0);
        chk("rst_req bus_addr",  b_addr,           32'd0);

        // ---------------- reset mid-RESP, late response ----------------
        txn(1'b0, 32'h200, 32'h0, 4'hF);
        run_vec(1100, mk(1,1,0,0,32'h0,0, 1,0,32'h0,0,0));
        run_vec(1101, mk(1,1,1,0,32'h0,0, 1,0,32'h0,0,1));
        run_vec(1102, mk(1,1,0,0,32'h0,0, 1,0,32'h0,0,0));
        @(negedge clk);
        req = 1'b0;
        #1;
        n_vec++;
        chk("pre_rst stall", {31'd0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        chk("rst_resp stall",  {31'd0, stall},   32'd0);
        chk("rst_resp rvalid", {31'd0, vld_o},   32'd0);
        chk("rst_resp rdata",  rdata_o,          32'd0);
        chk("rst_resp err",    {31'd0, err_o},   32'd0);
        chk("rst_resp bvalid", {31'd0, b_valid}, 32'd0);
        txn(1'b0, 32'h0, 32'h0, 4'h0);
        run_vec(1200, mk(0,0,0,1,32'h5A5A5A5A,0, 0,0,32'h0,0,0));
        run_vec(1201, mk(1,0,0,1,32'h5A5A5A5A,1, 0,0,32'h0,0,0));
        run_vec(1202, mk(1,0,0,0,32'h0,0,        0,0,32'h0,0,0));
        txn(1'b0, 32'h300, 32'h0, 4'hF);
        run_vec(1203, mk(1,1,0,0,32'h0,0,        1,0,32'h0,0,0));
        run_vec(1204, mk(1,1,1,0,32'h0,0,        1,0,32'h0,0,1));
        run_vec(1205, mk(1,1,0,1,32'h0BADF00D,0, 1,0,32'h0,0,0));
        run_vec(1206, mk(1,1,0,0,32'h0,0,        0,1,32'h0BADF00D,0,0));
        run_vec(1207, mk(1,0,0,0,32'h0,0,        0,0,32'h0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
